morse_digit_player: RTL and testbench
=====================================

Name: morse_digit_player

Overview:
- Parametrised successor to the single-digit Morse lookup.
- Takes the N_DIGITS seven-segment digit bus and converts a selected digit, or a run of digits, into 5-element Morse codes.
- Plays each code out serially on a timed key line with standard dot/dash/gap timing.
- Sits between the seven-segment display driver and the buzzer/LED key driver, controlled by a start/abort handshake.

Parameters:
- N_DIGITS, 8: number of digit channels on seg_bus (1..16).
- UNIT_CYCLES, 25000000: clk cycles per Morse time unit (>=2); benches use 4.
- DASH_UNITS, 3: dash length in units (>=2).
- CHAR_GAP_UNITS, 3: total silence between characters in sequence mode, in units (>=2).
- SELW, derived = max(1, clog2(N_DIGITS)): index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- seg_bus  in  8*N_DIGITS  digit i at [8i+7:8i], active-low segments, bit7 = dp.
- digit_sel  in  SELW  digit to play (single mode) or first digit (sequence mode).
- mode  in  1  0 = single digit, 1 = sequence digit_sel..N_DIGITS-1.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel.
- key_out  out  1  1 = tone on.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  invalid pattern or out-of-range digit_sel seen since last start.
- cur_digit  out  SELW  index being processed.
- morse_code  out  5  code of current digit (1 = dash, 0 = dot, bit4 sent first); 5'b10101 when idle, blank or invalid.

Behaviour:
- Reset (async): state IDLE; key_out=0, busy=0, done=0, err=0, cur_digit=0, morse_code=5'b10101. All outputs are registered.
- Decode table (segment pattern -> code):
  - F9 -> 01111; A4 -> 00111; B0 -> 00011; 99 -> 00001; 92 -> 00000
  - 82 -> 10000; F8 -> 11000; 80 -> 11100; 90 -> 11110; C0 -> 11111
  - FF = blank; any other pattern = invalid.
- FSM states: IDLE, LOAD, MARK, SPACE, CHAR_GAP, DONE.
- IDLE, start=1 and abort=0:
  - Snapshot seg_bus, mode and digit_sel into internal registers; later seg_bus changes have no effect.
  - Clear err; ptr = digit_sel; go to LOAD.
  - If digit_sel >= N_DIGITS: set err=1 and go to DONE.
- LOAD (1 cycle): cur_digit = ptr; decode the snapshot digit.
  - Valid: load morse_code, element index = 0, go to MARK.
  - Invalid: set err=1, then handle as blank.
  - Blank, mode 0 or ptr == N_DIGITS-1: go to DONE.
  - Blank, otherwise: ptr++ and stay in LOAD (one cycle per skipped digit).
- MARK: key_out=1 for UNIT_CYCLES (dot) or DASH_UNITS*UNIT_CYCLES (dash), per current element bit; then go to SPACE.
- SPACE: key_out=0 for UNIT_CYCLES, then:
  - element < 4: element++, go to MARK.
  - element == 4, mode 1 and ptr < N_DIGITS-1: go to CHAR_GAP.
  - Otherwise: go to DONE.
- CHAR_GAP: key_out=0 for (CHAR_GAP_UNITS-1)*UNIT_CYCLES, so total silence = CHAR_GAP_UNITS units; then ptr++ and go to LOAD. The gap is inserted even if the following digits are blank.
- DONE (1 cycle): done=1, busy=0, morse_code=5'b10101; go to IDLE.
- busy=1 in LOAD, MARK, SPACE and CHAR_GAP; 0 in IDLE and DONE.
- Latency: start sampled at edge k -> busy=1 after edge k+1 -> key_out=1 after edge k+2.
- start while busy: ignored.
- abort, any non-IDLE state: next edge enters IDLE with key_out=0, busy=0, morse_code=5'b10101; no done pulse; err keeps its value.
- abort and start in the same IDLE cycle: abort wins, remain in IDLE.
- Unit counter is cleared on every state entry; no drift across elements.

Test Plan (UNIT_CYCLES=4, DASH_UNITS=3, CHAR_GAP_UNITS=3, N_DIGITS=8):
- seg_bus digit2=F9, digit_sel=2, mode 0, start at edge k:
  - key_out high cycles k+2..k+5.
  - Then 4x (12 high, 4 low) following the first 4 low.
  - done=1 at edge k+74; morse_code=01111 during play; err=0.
- digit6=A4, digit7=FF, digit_sel=6, mode 1:
  - Plays 00111.
  - 8 extra silent cycles of CHAR_GAP.
  - LOAD with cur_digit=7 (blank), then DONE; err=0.
- digit0=88, digit_sel=0, mode 0, start at k: no key pulse; err=1; done at edge k+3; morse_code stays 10101.
- Abort mid dash of digit '0' (C0): key_out=0 and busy=0 next edge; no done; a new start 1 cycle later is accepted and replays from the first element.
- Change seg_bus and pulse start during playback: output waveform is identical to the unmodified run. Separately, assert rst asynchronously during MARK: all outputs reach reset values without a clk edge.
- Non-power-of-2 build (N_DIGITS=6) with digit_sel=7: err=1, done at edge k+2, key_out never high.

Source files
------------

// File: rtl/morse_digit_player.sv
// rtl/morse_digit_player.sv - plays seven-segment digits out as timed Morse code on a key line
module morse_digit_player #(
    parameter int N_DIGITS       = 8,
    parameter int UNIT_CYCLES    = 25000000,
    parameter int DASH_UNITS     = 3,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int SELW           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*N_DIGITS-1:0] seg_bus,
    input  logic [SELW-1:0]       digit_sel,
    input  logic                  mode,
    input  logic                  start,
    input  logic                  abort,
    output logic                  key_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [SELW-1:0]       cur_digit,
    output logic [4:0]            morse_code
);

    localparam int DOT_LEN  = UNIT_CYCLES;
    localparam int DASH_LEN = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_LEN  = (CHAR_GAP_UNITS - 1) * UNIT_CYCLES;
    localparam int MAX_LEN  = (DASH_LEN > GAP_LEN) ? DASH_LEN : GAP_LEN;
    localparam int CNTW     = $clog2(MAX_LEN);
    localparam bit POW2     = ((1 << SELW) == N_DIGITS);

    localparam logic [CNTW-1:0] DOT_END  = CNTW'(DOT_LEN - 1);
    localparam logic [CNTW-1:0] DASH_END = CNTW'(DASH_LEN - 1);
    localparam logic [CNTW-1:0] GAP_END  = CNTW'(GAP_LEN - 1);
    localparam logic [SELW-1:0] LAST_PTR = SELW'(N_DIGITS - 1);
    localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N_DIGITS);
    localparam logic [4:0]      IDLE_CODE = 5'b10101;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MARK, S_SPACE, S_CHAR_GAP, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [SELW-1:0]       ptr_q, ptr_d;
    logic [2:0]            elem_q, elem_d;
    logic [4:0]            code_q, code_d;
    logic [8*N_DIGITS-1:0] seg_snap_q, seg_snap_d;
    logic                  mode_snap_q, mode_snap_d;
    logic                  err_q, err_d;
    logic                  key_out_q, key_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [SELW-1:0]       cur_digit_q, cur_digit_d;
    logic [4:0]            morse_code_q, morse_code_d;

    logic                  ptr_in_range;
    logic                  sel_in_range;
    logic [7:0]            cur_seg;
    logic                  dec_valid;
    logic                  dec_blank;
    logic [4:0]            dec_code;
    logic                  cur_bit;

    // Non-power-of-two builds can be handed an index past the last digit
    generate
        if (POW2) begin : g_full_range
            assign ptr_in_range = 1'b1;
            assign sel_in_range = 1'b1;
        end else begin : g_part_range
            assign ptr_in_range = ({1'b0, ptr_q} < N_EXT);
            assign sel_in_range = ({1'b0, digit_sel} < N_EXT);
        end
    endgenerate

    assign cur_bit = code_q[3'd4 - elem_q];

    // Pick the snapshot byte for ptr and translate it to a Morse code
    always_comb begin
        cur_seg   = 8'hFF;
        dec_valid = 1'b1;
        dec_blank = 1'b0;
        dec_code  = 5'b00000;
        if (ptr_in_range) begin
            cur_seg = seg_snap_q[{ptr_q, 3'b000} +: 8];
        end
        case (cur_seg)
            8'hF9:   dec_code = 5'b01111;
            8'hA4:   dec_code = 5'b00111;
            8'hB0:   dec_code = 5'b00011;
            8'h99:   dec_code = 5'b00001;
            8'h92:   dec_code = 5'b00000;
            8'h82:   dec_code = 5'b10000;
            8'hF8:   dec_code = 5'b11000;
            8'h80:   dec_code = 5'b11100;
            8'h90:   dec_code = 5'b11110;
            8'hC0:   dec_code = 5'b11111;
            8'hFF: begin
                dec_valid = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // Sequencer: next state, snapshot, pointer and element bookkeeping
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        elem_d      = elem_q;
        code_d      = code_q;
        seg_snap_d  = seg_snap_q;
        mode_snap_d = mode_snap_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    seg_snap_d  = seg_bus;
                    mode_snap_d = mode;
                    ptr_d       = digit_sel;
                    err_d       = !sel_in_range;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!ptr_in_range) begin
                    state_d = S_DONE;
                end else if (dec_valid) begin
                    code_d  = dec_code;
                    elem_d  = 3'd0;
                    state_d = S_MARK;
                end else if (!dec_blank) begin
                    // Invalid byte is flagged, then overwritten so the next
                    // LOAD cycle treats it exactly like a blank digit.
                    err_d = 1'b1;
                    seg_snap_d[{ptr_q, 3'b000} +: 8] = 8'hFF;
                end else if (!mode_snap_q || ptr_q == LAST_PTR) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + SELW'(1);
                end
            end
            S_MARK: begin
                if (cnt_q == (cur_bit ? DASH_END : DOT_END)) begin
                    state_d = S_SPACE;
                end
            end
            S_SPACE: begin
                if (cnt_q == DOT_END) begin
                    if (elem_q != 3'd4) begin
                        elem_d  = elem_q + 3'd1;
                        state_d = S_MARK;
                    end else if (mode_snap_q && ptr_q != LAST_PTR) begin
                        state_d = S_CHAR_GAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CHAR_GAP: begin
                if (cnt_q == GAP_END) begin
                    ptr_d   = ptr_q + SELW'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // Unit counter restarts on every state entry so element lengths never drift
    always_comb begin
        cnt_d = (state_d == state_q) ? cnt_q + CNTW'(1) : '0;
    end

    // Output values follow the state one cycle later; abort forces idle values
    always_comb begin
        key_out_d    = (state_q == S_MARK);
        busy_d       = (state_q == S_LOAD) || (state_q == S_MARK) ||
                       (state_q == S_SPACE) || (state_q == S_CHAR_GAP);
        done_d       = (state_q == S_DONE);
        cur_digit_d  = cur_digit_q;
        morse_code_d = morse_code_q;
        case (state_q)
            S_IDLE, S_DONE: morse_code_d = IDLE_CODE;
            S_LOAD: begin
                cur_digit_d  = ptr_q;
                morse_code_d = (ptr_in_range && dec_valid) ? dec_code : IDLE_CODE;
            end
            default: ;
        endcase
        if (abort && state_q != S_IDLE) begin
            key_out_d    = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            morse_code_d = IDLE_CODE;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            elem_q       <= 3'd0;
            code_q       <= IDLE_CODE;
            seg_snap_q   <= '1;
            mode_snap_q  <= 1'b0;
            err_q        <= 1'b0;
            key_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cur_digit_q  <= '0;
            morse_code_q <= IDLE_CODE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            elem_q       <= elem_d;
            code_q       <= code_d;
            seg_snap_q   <= seg_snap_d;
            mode_snap_q  <= mode_snap_d;
            err_q        <= err_d;
            key_out_q    <= key_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cur_digit_q  <= cur_digit_d;
            morse_code_q <= morse_code_d;
        end
    end

    assign key_out    = key_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cur_digit  = cur_digit_q;
    assign morse_code = morse_code_q;

endmodule

// File: tb/tb_morse_digit_player.sv
// tb/tb_morse_digit_player.sv - self-checking bench for morse_digit_player
module tb_morse_digit_player;

    localparam int N  = 8;
    localparam int U  = 4;
    localparam int DU = 3;
    localparam int CG = 3;

    typedef struct packed {
        logic       key;
        logic       chk;
        logic [4:0] code;
        logic [2:0] dig;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] seg_bus;
    logic [2:0]  digit_sel;
    logic        mode, start, abort;
    logic        key_out, busy, done, err;
    logic [2:0]  cur_digit;
    logic [4:0]  morse_code;

    logic [47:0] seg_b;
    logic [2:0]  sel_b;
    logic        mode_b, start_b, abort_b;
    logic        key_b, busy_b, done_b, err_b;
    logic [2:0]  cur_b;
    logic [4:0]  code_b;

    int checks = 0;
    int errors = 0;

    step_t exp_q[$];
    logic  exp_err;
    int    exp_last;
    logic [7:0] seg7 [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    morse_digit_player #(.N_DIGITS(N), .UNIT_CYCLES(U), .DASH_UNITS(DU),
                         .CHAR_GAP_UNITS(CG)) dut (
        .clk(clk), .rst(rst), .seg_bus(seg_bus), .digit_sel(digit_sel),
        .mode(mode), .start(start), .abort(abort), .key_out(key_out),
        .busy(busy), .done(done), .err(err), .cur_digit(cur_digit),
        .morse_code(morse_code)
    );

    morse_digit_player #(.N_DIGITS(6), .UNIT_CYCLES(U), .DASH_UNITS(DU),
                         .CHAR_GAP_UNITS(CG)) dut6 (
        .clk(clk), .rst(rst), .seg_bus(seg_b), .digit_sel(sel_b),
        .mode(mode_b), .start(start_b), .abort(abort_b), .key_out(key_b),
        .busy(busy_b), .done(done_b), .err(err_b), .cur_digit(cur_b),
        .morse_code(code_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // 0..9 for a digit pattern, 10 for blank, -1 for anything else
    function automatic int pat_digit(input logic [7:0] p);
        if (p == 8'hFF) return 10;
        for (int d = 0; d < 10; d++) if (seg7[d] == p) return d;
        return -1;
    endfunction

    // Digits 1..5 start with d dots, 6..9 start with d-5 dashes, 0 is all dashes
    function automatic logic [4:0] morse_of(input int d);
        logic [4:0] c;
        int nd;
        for (int p = 0; p < 5; p++) begin
            if (d >= 1 && d <= 5) c[4-p] = (p >= d);
            else begin
                nd = (d == 0) ? 5 : d - 5;
                c[4-p] = (p < nd);
            end
        end
        return c;
    endfunction

    function automatic void push(input logic k, input logic c, input logic [4:0] cd,
                                 input int dig, input int n);
        step_t s;
        s.key = k; s.chk = c; s.code = cd; s.dig = 3'(dig);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endfunction

    // Cycle-by-cycle expected key line for one transmission, starting one
    // cycle after the start edge and ending just before the done pulse
    function automatic void build(input logic [63:0] seg, input int sel, input logic md);
        int p, d;
        logic [4:0] c;
        exp_q.delete();
        exp_err = 1'b0;
        p = sel;
        while (1) begin
            d = pat_digit(seg[8*p +: 8]);
            exp_last = p;
            if (d < 0) begin
                exp_err = 1'b1;
                push(1'b0, 1'b0, 5'b0, p, 1);
                d = 10;
            end
            push(1'b0, 1'b0, 5'b0, p, 1);
            if (d == 10) begin
                if (!md || p == N - 1) break;
                p++;
                continue;
            end
            c = morse_of(d);
            for (int e = 0; e < 5; e++) begin
                push(1'b1, 1'b1, c, p, c[4-e] ? DU * U : U);
                push(1'b0, 1'b0, c, p, U);
            end
            if (md && p < N - 1) begin
                push(1'b0, 1'b0, c, p, (CG - 1) * U);
                p++;
            end else break;
        end
    endfunction

    task automatic run_play(input logic [63:0] seg, input int sel, input logic md, input bit wig);
        build(seg, sel, md);
        seg_bus = seg; digit_sel = 3'(sel); mode = md; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_at_start_edge", 32'(busy), 32'(0));
        chk("done_at_start_edge", 32'(done), 32'(0));
        foreach (exp_q[i]) begin
            if (wig) begin
                seg_bus   = {$urandom, $urandom};
                digit_sel = 3'($urandom);
                mode      = 1'($urandom);
                start     = 1'($urandom);
            end
            tick();
            chk("key_out", 32'(key_out), 32'(exp_q[i].key));
            chk("busy_play", 32'(busy), 32'(1));
            if (exp_q[i].chk) begin
                chk("morse_code_play", 32'(morse_code), 32'(exp_q[i].code));
                chk("cur_digit_play", 32'(cur_digit), 32'(exp_q[i].dig));
            end
        end
        start = 1'b0;
        tick();
        chk("done_pulse", 32'(done), 32'(1));
        chk("busy_done", 32'(busy), 32'(0));
        chk("key_done", 32'(key_out), 32'(0));
        chk("morse_done", 32'(morse_code), 32'(5'b10101));
        chk("err_done", 32'(err), 32'(exp_err));
        chk("cur_digit_done", 32'(cur_digit), 32'(exp_last));
        tick();
        chk("done_one_cycle", 32'(done), 32'(0));
    endtask

    initial begin
        logic [63:0] s;
        int r;
        logic [7:0] b;

        rst = 1'b1; seg_bus = '1; digit_sel = '0; mode = 1'b0; start = 1'b0; abort = 1'b0;
        seg_b = '1; sel_b = '0; mode_b = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        repeat (3) tick();
        chk("rst_key", 32'(key_out), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_cur", 32'(cur_digit), 32'(0));
        chk("rst_morse", 32'(morse_code), 32'(5'b10101));
        rst = 1'b0;
        tick();

        // Digit '1' on channel 2, single mode
        s = '1; s[23:16] = 8'hF9;
        run_play(s, 2, 1'b0, 1'b0);

        // Digit '2' then a blank in sequence mode
        s = '1; s[55:48] = 8'hA4;
        run_play(s, 6, 1'b1, 1'b0);

        // Invalid pattern
        s = '1; s[7:0] = 8'h88;
        run_play(s, 0, 1'b0, 1'b0);

        // abort and start together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy0", 32'(busy), 32'(0));
        tick();
        chk("abort_start_busy1", 32'(busy), 32'(0));

        // Abort in the middle of the first dash of '0', then replay
        s = '1; s[7:0] = 8'hC0;
        seg_bus = s; digit_sel = 3'd0; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_abort_key", 32'(key_out), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_key", 32'(key_out), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_morse", 32'(morse_code), 32'(5'b10101));
        run_play(s, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a mark
        s = '1; s[23:16] = 8'hF9;
        seg_bus = s; digit_sel = 3'd2; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("pre_rst_key", 32'(key_out), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_key", 32'(key_out), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_morse", 32'(morse_code), 32'(5'b10101));
        chk("arst_cur", 32'(cur_digit), 32'(0));
        #1 rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'(0));

        // Randomised runs with input churn during playback
        for (int run = 0; run < 16; run++) begin
            for (int d = 0; d < N; d++) begin
                r = $urandom_range(0, 11);
                if (r < 10) b = seg7[r];
                else if (r == 10) b = 8'hFF;
                else begin
                    b = 8'($urandom_range(0, 255));
                    while (pat_digit(b) != -1) b = 8'($urandom_range(0, 255));
                end
                s[8*d +: 8] = b;
            end
            run_play(s, $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Six-digit build, digit_sel beyond the last channel
        seg_b = {6{8'hF9}}; sel_b = 3'd7; mode_b = 1'b0; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("n6_err_k", 32'(err_b), 32'(1));
        chk("n6_key_k", 32'(key_b), 32'(0));
        tick();
        chk("n6_done_k1", 32'(done_b), 32'(0));
        chk("n6_busy_k1", 32'(busy_b), 32'(1));
        chk("n6_key_k1", 32'(key_b), 32'(0));
        tick();
        chk("n6_done_k2", 32'(done_b), 32'(1));
        chk("n6_key_k2", 32'(key_b), 32'(0));
        chk("n6_err_k2", 32'(err_b), 32'(1));
        tick();
        chk("n6_done_k3", 32'(done_b), 32'(0));
        chk("n6_key_k3", 32'(key_b), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
